// File: rtl/stage_ctrl_pkg.sv
// Shared definitions for the stage_ctrl sequencer: stage encodings, RV32I opcodes,
// opcode classes and the per-class operand-latch usage record.
package stage_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_MEMORY    = 3'd3,
        ST_WRITEBACK = 3'd4,
        ST_TRAP      = 3'd7
    } stage_t;

    localparam logic [6:0] OPCODE_MASK = 7'b111_1111;

    localparam logic [6:0] OP_ALU_R  = 7'b0110011;
    localparam logic [6:0] OP_ALU_I  = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        CLS_ALU_R,
        CLS_ALU_I,
        CLS_LUI,
        CLS_AUIPC,
        CLS_JAL,
        CLS_JALR,
        CLS_LOAD,
        CLS_STORE,
        CLS_BRANCH,
        CLS_ILLEGAL
    } op_class_t;

    typedef struct packed {
        logic a;
        logic b;
        logic pass;
    } strobe_use_t;

    function automatic logic is_jump(input op_class_t cls);
        return (cls == CLS_JAL) || (cls == CLS_JALR);
    endfunction

endpackage

// File: rtl/stage_ctrl_op_classify.sv
// op_classify: maps an instruction opcode field to its class and to the
// operand-latch strobes that class uses during DECODE.
module op_classify
    import stage_ctrl_pkg::*;
(
    input  logic [6:0]  opcode,
    output op_class_t   op_class,
    output strobe_use_t use_strobe
);

    always_comb begin
        op_class   = CLS_ILLEGAL;
        use_strobe = '0;
        case (opcode & OPCODE_MASK)
            OP_ALU_R: begin
                op_class   = CLS_ALU_R;
                use_strobe = '{a: 1'b1, b: 1'b1, pass: 1'b0};
            end
            OP_ALU_I: begin
                op_class   = CLS_ALU_I;
                use_strobe = '{a: 1'b1, b: 1'b0, pass: 1'b1};
            end
            OP_LUI: begin
                op_class   = CLS_LUI;
                use_strobe = '{a: 1'b0, b: 1'b0, pass: 1'b1};
            end
            OP_AUIPC: begin
                op_class   = CLS_AUIPC;
                use_strobe = '{a: 1'b0, b: 1'b0, pass: 1'b1};
            end
            OP_JAL: begin
                op_class   = CLS_JAL;
                use_strobe = '{a: 1'b0, b: 1'b0, pass: 1'b1};
            end
            OP_JALR: begin
                op_class   = CLS_JALR;
                use_strobe = '{a: 1'b1, b: 1'b0, pass: 1'b1};
            end
            OP_LOAD: begin
                op_class   = CLS_LOAD;
                use_strobe = '{a: 1'b1, b: 1'b0, pass: 1'b1};
            end
            OP_STORE: begin
                op_class   = CLS_STORE;
                use_strobe = '{a: 1'b1, b: 1'b1, pass: 1'b1};
            end
            OP_BRANCH: begin
                op_class   = CLS_BRANCH;
                use_strobe = '{a: 1'b1, b: 1'b1, pass: 1'b0};
            end
            default: begin
                op_class   = CLS_ILLEGAL;
                use_strobe = '0;
            end
        endcase
    end

endmodule

// File: rtl/stage_ctrl.sv
// stage_ctrl: multi-cycle RV32I sequencer owning PC, IR, stage FSM and memory handshake.
// Build option STAGE_CTRL_ILLEGAL_TRAP_EN: illegal opcodes lock in TRAP instead of acting as NOPs.
module stage_ctrl
    import stage_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        halt_i,
    output logic        mem_req_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    input  logic [31:0] alu_result_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    output logic [31:0] pc_o,
    output logic [31:0] ir_o,
    output logic [2:0]  stage_o,
    output logic        readin_a_o,
    output logic        readin_b_o,
    output logic        readin_pass_o,
    output logic        rf_we_o,
    output logic [4:0]  rd_o,
    output logic        trap_o
);

    stage_t      state, state_n;
    logic        req, req_n;
    logic [31:0] pc, pc_n;
    logic [31:0] ir, ir_n;
    logic [31:0] npc, npc_n;
    logic [31:0] addr, addr_n;
    op_class_t   op_class;
    strobe_use_t uses;
    logic [31:0] seq_pc;
    logic [31:0] exec_pc;
    logic        take;
    logic        ack;

    op_classify u_op_classify (
        .opcode     (ir[6:0]),
        .op_class   (op_class),
        .use_strobe (uses)
    );

    assign seq_pc  = pc + 32'd4;
    assign take    = is_jump(op_class) || ((op_class == CLS_BRANCH) && branch_taken_i);
    assign exec_pc = take ? branch_target_i : seq_pc;
    assign ack     = req && mem_ack_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_FETCH;
            req   <= 1'b1;
            pc    <= RESET_PC;
            ir    <= '0;
            npc   <= RESET_PC;
            addr  <= '0;
        end else begin
            state <= state_n;
            req   <= req_n;
            pc    <= pc_n;
            ir    <= ir_n;
            npc   <= npc_n;
            addr  <= addr_n;
        end
    end

    // req is the registered request: it is set on the edge entering FETCH (halt_i
    // sampled there) or MEMORY, and only an ack can clear it once raised.
    always_comb begin
        state_n = state;
        req_n   = req;
        pc_n    = pc;
        ir_n    = ir;
        npc_n   = npc;
        addr_n  = addr;
        case (state)
            ST_FETCH: begin
                if (req) begin
                    if (ack) begin
                        ir_n    = mem_rdata_i;
                        req_n   = 1'b0;
                        state_n = ST_DECODE;
                    end
                end else begin
                    req_n = !halt_i;
                end
            end
            ST_DECODE: begin
                if (op_class == CLS_ILLEGAL) begin
`ifdef STAGE_CTRL_ILLEGAL_TRAP_EN
                    state_n = ST_TRAP;
`else
                    state_n = ST_FETCH;
                    pc_n    = seq_pc;
                    req_n   = !halt_i;
`endif
                end else begin
                    state_n = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                npc_n  = exec_pc;
                addr_n = alu_result_i;
                case (op_class)
                    CLS_LOAD, CLS_STORE: begin
                        state_n = ST_MEMORY;
                        req_n   = 1'b1;
                    end
                    CLS_BRANCH: begin
                        state_n = ST_FETCH;
                        pc_n    = exec_pc;
                        req_n   = !halt_i;
                    end
                    default: state_n = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                if (ack) begin
                    req_n = 1'b0;
                    if (op_class == CLS_STORE) begin
                        state_n = ST_FETCH;
                        pc_n    = npc;
                        req_n   = !halt_i;
                    end else begin
                        state_n = ST_WRITEBACK;
                    end
                end
            end
            ST_WRITEBACK: begin
                state_n = ST_FETCH;
                pc_n    = npc;
                req_n   = !halt_i;
            end
            ST_TRAP: begin
                state_n = ST_TRAP;
                req_n   = 1'b0;
            end
            default: begin
                state_n = ST_FETCH;
                req_n   = !halt_i;
            end
        endcase
    end

    assign mem_req_o     = req && !reset;
    assign mem_we_o      = mem_req_o && (state == ST_MEMORY) && (op_class == CLS_STORE);
    assign mem_addr_o    = (state == ST_MEMORY) ? addr : pc;
    assign pc_o          = pc;
    assign ir_o          = ir;
    assign stage_o       = state;
    assign rd_o          = ir[11:7];
    assign readin_a_o    = (state == ST_DECODE) && uses.a;
    assign readin_b_o    = (state == ST_DECODE) && uses.b;
    assign readin_pass_o = (state == ST_DECODE) && uses.pass;
    assign rf_we_o       = (state == ST_WRITEBACK) && (ir[11:7] != 5'd0);
`ifdef STAGE_CTRL_ILLEGAL_TRAP_EN
    assign trap_o        = (state == ST_TRAP);
`else
    assign trap_o        = 1'b0;
`endif

endmodule

// File: tb/tb_stage_ctrl.sv
// Bench for stage_ctrl: a table of instructions whose expectations flow through a
// scoreboard queue, plus hand sequences for halt, reset during a store and illegal opcodes.
`timescale 1ns/1ps
module tb_stage_ctrl;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        halt_i = 1'b0;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i = '0;
    logic [31:0] alu_result_i = '0;
    logic        branch_taken_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic [31:0] pc_o, ir_o;
    logic [2:0]  stage_o;
    logic        readin_a_o, readin_b_o, readin_pass_o, rf_we_o, trap_o;
    logic [4:0]  rd_o;

    stage_ctrl #(.RESET_PC(RST_PC)) dut (
        .clk             (clk),
        .reset           (reset),
        .halt_i          (halt_i),
        .mem_req_o       (mem_req_o),
        .mem_we_o        (mem_we_o),
        .mem_addr_o      (mem_addr_o),
        .mem_ack_i       (mem_ack_i),
        .mem_rdata_i     (mem_rdata_i),
        .alu_result_i    (alu_result_i),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .pc_o            (pc_o),
        .ir_o            (ir_o),
        .stage_o         (stage_o),
        .readin_a_o      (readin_a_o),
        .readin_b_o      (readin_b_o),
        .readin_pass_o   (readin_pass_o),
        .rf_we_o         (rf_we_o),
        .rd_o            (rd_o),
        .trap_o          (trap_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        int          fwait;
        int          mwait;
        logic [31:0] alu;
        logic        taken;
        logic [31:0] tgt;
        int          lat;
        int          a;
        int          b;
        int          pass;
        int          we;
        logic [4:0]  rd;
        int          memc;
        logic        st;
        logic [31:0] pc_after;
    } vec_t;

    vec_t        tbl [14];
    vec_t        sb [$];
    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] cur_instr = '0;
    logic [31:0] exp_pc = RST_PC;
    int          fetch_wait = 0;
    int          mem_wait = 0;
    int          wait_left = 0;
    logic        busy = 1'b0;

    function automatic vec_t mk(input logic [31:0] instr, input int fw, input int mw,
                                input logic [31:0] alu, input logic taken, input logic [31:0] tgt,
                                input int lat, input int a, input int b, input int pass,
                                input int we, input logic [4:0] rd, input int memc,
                                input logic st, input logic [31:0] pc_after);
        vec_t v;
        v.instr = instr; v.fwait = fw; v.mwait = mw; v.alu = alu; v.taken = taken; v.tgt = tgt;
        v.lat = lat; v.a = a; v.b = b; v.pass = pass; v.we = we; v.rd = rd; v.memc = memc;
        v.st = st; v.pc_after = pc_after;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Memory responder, called once per cycle just after the falling edge.
    task automatic drive_mem();
        mem_ack_i = 1'b0;
        if (mem_req_o) begin
            if (!busy) begin
                busy      = 1'b1;
                wait_left = (stage_o == 3'd3) ? mem_wait : fetch_wait;
            end
            if (wait_left == 0) begin
                mem_ack_i = 1'b1;
                busy      = 1'b0;
            end else begin
                wait_left--;
            end
        end
        mem_rdata_i = (stage_o == 3'd3) ? 32'hCAFE_F00D : cur_instr;
    endtask

    // Entered at the falling edge of the instruction's first FETCH cycle; returns at
    // the falling edge of the following instruction's first FETCH cycle.
    task automatic run_vec(input vec_t v);
        vec_t        e;
        int          cyc, a_c, b_c, p_c, we_c, memc;
        logic        left, done;
        logic [31:0] faddr, irq;
        logic [4:0]  rdq;
        cur_instr       = v.instr;
        fetch_wait      = v.fwait;
        mem_wait        = v.mwait;
        alu_result_i    = v.alu;
        branch_taken_i  = v.taken;
        branch_target_i = v.tgt;
        sb.push_back(v);
        cyc = 1; a_c = 0; b_c = 0; p_c = 0; we_c = 0; memc = 0;
        left = 1'b0; done = 1'b0; irq = '0; rdq = '0;
        faddr = mem_addr_o;
        drive_mem();
        for (int k = 0; k < 64 && !done; k++) begin
            @(negedge clk);
            if (stage_o == 3'd0 && left) begin
                done = 1'b1;
            end else begin
                cyc++;
                if (stage_o != 3'd0) left = 1'b1;
                if (stage_o == 3'd1) irq = ir_o;
                a_c += int'(readin_a_o);
                b_c += int'(readin_b_o);
                p_c += int'(readin_pass_o);
                if (rf_we_o) begin
                    we_c++;
                    rdq = rd_o;
                end
                if (stage_o == 3'd3 && mem_req_o && mem_addr_o == v.alu && mem_we_o == v.st) memc++;
                drive_mem();
            end
        end
        e = sb.pop_front();
        if (!done) chk("instr_timeout", 32'd0, 32'd1);
        chk("latency", cyc, e.lat);
        chk("fetch_addr", faddr, exp_pc);
        chk("ir_latched", irq, e.instr);
        chk("readin_a", a_c, e.a);
        chk("readin_b", b_c, e.b);
        chk("readin_pass", p_c, e.pass);
        chk("rf_we_pulses", we_c, e.we);
        if (e.we != 0) chk("rd", {27'd0, rdq}, {27'd0, e.rd});
        chk("mem_cycles", memc, e.memc);
        chk("pc_next", pc_o, e.pc_after);
        exp_pc = e.pc_after;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  m;
        logic done;

        //          instr          fw mw alu           tk  tgt           lat a  b  p  we rd memc st pc_after
        tbl[0]  = mk(32'h002081B3, 0, 0, 32'h0,        0, 32'h0,        4, 1, 1, 0, 1, 3, 0, 0, 32'h0000_0104);
        tbl[1]  = mk(32'h0000A283, 0, 2, 32'h2000,     0, 32'h0,        7, 1, 0, 1, 1, 5, 3, 0, 32'h0000_0108);
        tbl[2]  = mk(32'h00208463, 0, 0, 32'h0,        1, 32'h80,       3, 1, 1, 0, 0, 0, 0, 0, 32'h0000_0080);
        tbl[3]  = mk(32'h00208463, 0, 0, 32'h0,        0, 32'h400,      3, 1, 1, 0, 0, 0, 0, 0, 32'h0000_0084);
        tbl[4]  = mk(32'h0020A023, 0, 1, 32'h3000,     0, 32'h0,        5, 1, 1, 1, 0, 0, 2, 1, 32'h0000_0088);
        tbl[5]  = mk(32'h00000013, 0, 0, 32'h0,        0, 32'h0,        4, 1, 0, 1, 0, 0, 0, 0, 32'h0000_008C);
        tbl[6]  = mk(32'h002081B3, 3, 0, 32'h0,        0, 32'h0,        7, 1, 1, 0, 1, 3, 0, 0, 32'h0000_0090);
        tbl[7]  = mk(32'h008000EF, 0, 0, 32'h0,        0, 32'h200,      4, 0, 0, 1, 1, 1, 0, 0, 32'h0000_0200);
        tbl[8]  = mk(32'h123453B7, 0, 0, 32'h0,        0, 32'h0,        4, 0, 0, 1, 1, 7, 0, 0, 32'h0000_0204);
        tbl[9]  = mk(32'h00000117, 0, 0, 32'h0,        0, 32'h0,        4, 0, 0, 1, 1, 2, 0, 0, 32'h0000_0208);
        tbl[10] = mk(32'h00008067, 0, 0, 32'h0,        1, 32'hFFFF_FFFC,4, 1, 0, 1, 0, 0, 0, 0, 32'hFFFF_FFFC);
        tbl[11] = mk(32'h00000013, 0, 0, 32'h0,        0, 32'h0,        4, 1, 0, 1, 0, 0, 0, 0, 32'h0000_0000);
        tbl[12] = mk(32'h0020A023, 1, 0, 32'h40,       0, 32'h0,        5, 1, 1, 1, 0, 0, 1, 1, 32'h0000_0004);
        tbl[13] = mk(32'h00208463, 0, 0, 32'h0,        1, 32'h10,       3, 1, 1, 0, 0, 0, 0, 0, 32'h0000_0010);

        // Reset state, with mem_req_o held low while reset is asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_stage", {29'd0, stage_o}, 32'd0);
        chk("rst_pc", pc_o, RST_PC);
        chk("rst_ir", ir_o, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
        chk("rst_flags", {27'd0, readin_a_o, readin_b_o, readin_pass_o, rf_we_o, trap_o}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        exp_pc = RST_PC;

        for (int i = 0; i < 14; i++) run_vec(tbl[i]);

        // halt_i rises during a fetch that is already requesting: the fetch completes,
        // then the next boundary holds with no request and ignores stray acks.
        halt_i = 1'b1;
        run_vec(mk(32'h002081B3, 0, 0, 32'h0, 0, 32'h0, 4, 1, 1, 0, 1, 3, 0, 0, 32'h0000_0014));
        for (int k = 0; k < 5; k++) begin
            chk("halt_req", {31'd0, mem_req_o}, 32'd0);
            chk("halt_stage", {29'd0, stage_o}, 32'd0);
            mem_ack_i   = 1'b1;
            mem_rdata_i = 32'h0000_007F;
            @(negedge clk);
        end
        chk("halt_ir_kept", ir_o, 32'h002081B3);
        chk("halt_pc_kept", pc_o, 32'h0000_0014);
        halt_i    = 1'b0;
        mem_ack_i = 1'b0;
        @(negedge clk);
        chk("release_req", {31'd0, mem_req_o}, 32'd1);

        // Reset while a store waits in MEMORY (an ack lines up with the reset edge)
        cur_instr    = 32'h0020A023;
        fetch_wait   = 0;
        mem_wait     = 20;
        alu_result_i = 32'h5000;
        m = 0;
        done = 1'b0;
        drive_mem();
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (stage_o == 3'd3) m++;
            if (m == 2) done = 1'b1;
            else drive_mem();
        end
        chk("store_mem_stage", {29'd0, stage_o}, 32'd3);
        chk("store_we", {31'd0, mem_we_o}, 32'd1);
        reset     = 1'b1;
        mem_ack_i = 1'b1;
        #1;
        chk("rst_gates_req", {31'd0, mem_req_o}, 32'd0);
        chk("rst_gates_we", {31'd0, mem_we_o}, 32'd0);
        @(negedge clk);
        chk("abort_stage", {29'd0, stage_o}, 32'd0);
        chk("abort_pc", pc_o, RST_PC);
        chk("abort_rf_we", {31'd0, rf_we_o}, 32'd0);
        reset     = 1'b0;
        mem_ack_i = 1'b0;
        busy      = 1'b0;
        @(negedge clk);
        chk("post_reset_req", {31'd0, mem_req_o}, 32'd1);
        exp_pc = RST_PC;

`ifdef STAGE_CTRL_ILLEGAL_TRAP_EN
        cur_instr  = 32'h0000_007F;
        fetch_wait = 0;
        done = 1'b0;
        drive_mem();
        for (int k = 0; k < 8 && !done; k++) begin
            @(negedge clk);
            if (stage_o == 3'd7) done = 1'b1;
            else drive_mem();
        end
        for (int k = 0; k < 5; k++) begin
            chk("trap_stage", {29'd0, stage_o}, 32'd7);
            chk("trap_flag", {31'd0, trap_o}, 32'd1);
            chk("trap_no_req", {31'd0, mem_req_o}, 32'd0);
            chk("trap_pc", pc_o, RST_PC);
            chk("trap_strobes", {29'd0, readin_a_o, readin_b_o, readin_pass_o}, 32'd0);
            mem_ack_i = 1'b1;
            @(negedge clk);
        end
        reset     = 1'b1;
        mem_ack_i = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("trap_exit_stage", {29'd0, stage_o}, 32'd0);
        chk("trap_exit_flag", {31'd0, trap_o}, 32'd0);
`else
        run_vec(mk(32'h0000_007F, 0, 0, 32'h0, 0, 32'h0, 2, 0, 0, 0, 0, 0, 0, 0, RST_PC + 32'd4));
        chk("illegal_trap_flag", {31'd0, trap_o}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
